// File: rtl/vga_pattern_gen.sv
// Test-pattern source: recovers column/row from active-region syncs and emits
// syncs plus RGB pattern data at a fixed two-cycle latency.
module vga_pattern_gen #(
   parameter int unsigned VIDEO_WIDTH = 3,
   parameter int unsigned TOTAL_COLS  = 800,
   parameter int unsigned TOTAL_ROWS  = 525,
   parameter int unsigned ACTIVE_COLS = 640,
   parameter int unsigned ACTIVE_ROWS = 480
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   ihsync,
   input  logic                   ivsync,
   input  logic [2:0]             ipattern,
   output logic                   ohsync,
   output logic                   ovsync,
   output logic [VIDEO_WIDTH-1:0] oredv,
   output logic [VIDEO_WIDTH-1:0] ogrnv,
   output logic [VIDEO_WIDTH-1:0] obluv,
   output logic                   olocked
);

   typedef enum logic [2:0] {
      PAT_BLACK    = 3'd0,
      PAT_RED      = 3'd1,
      PAT_GREEN    = 3'd2,
      PAT_BLUE     = 3'd3,
      PAT_CHECKER  = 3'd4,
      PAT_BARS     = 3'd5,
      PAT_BORDER   = 3'd6,
      PAT_GRADIENT = 3'd7
   } pattern_t;

   localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
   localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
   localparam logic [9:0] ACT_COLS = 10'(ACTIVE_COLS);
   localparam logic [9:0] ACT_ROWS = 10'(ACTIVE_ROWS);
   localparam logic [9:0] EDGE_COL = 10'(ACTIVE_COLS - 1);
   localparam logic [9:0] EDGE_ROW = 10'(ACTIVE_ROWS - 1);
   localparam int unsigned BAR_W   = ACTIVE_COLS / 8;
   localparam logic [VIDEO_WIDTH-1:0] FULL = '1;

   logic       s_hsync;
   logic       s_vsync;
   logic       fs;
   logic       locked;
   logic [9:0] col;
   logic [9:0] row;
   pattern_t   pat_q;

   logic                   in_active;
   logic [2:0]             bar_k;
   logic [VIDEO_WIDTH-1:0] pix_r;
   logic [VIDEO_WIDTH-1:0] pix_g;
   logic [VIDEO_WIDTH-1:0] pix_b;

   always_comb begin
      fs = ivsync & ~s_vsync;
   end

   // Stage 1: s_vsync resets high so a held-high ivsync cannot fake a frame start.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         s_hsync <= 1'b0;
         s_vsync <= 1'b1;
         col     <= '0;
         row     <= '0;
         pat_q   <= PAT_BLACK;
         locked  <= 1'b0;
      end else begin
         s_hsync <= ihsync;
         s_vsync <= ivsync;
         if (fs) begin
            col    <= '0;
            row    <= '0;
            pat_q  <= pattern_t'(ipattern);
            locked <= 1'b1;
         end else if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 10'd1;
         end else begin
            col <= col + 10'd1;
         end
      end
   end

   // Bar index from threshold compares, avoiding a divider by a non-power-of-two width.
   always_comb begin
      bar_k = '0;
      for (int unsigned i = 1; i < 8; i++) begin
         if (col >= 10'(i * BAR_W)) bar_k = 3'(i);
      end
   end

   always_comb begin
      in_active = locked && (col < ACT_COLS) && (row < ACT_ROWS);
   end

   always_comb begin
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
      if (in_active) begin
         case (pat_q)
            PAT_BLACK: ;
            PAT_RED:   pix_r = FULL;
            PAT_GREEN: pix_g = FULL;
            PAT_BLUE:  pix_b = FULL;
            PAT_CHECKER: begin
               if (col[5] ^ row[5]) begin
                  pix_r = FULL;
                  pix_g = FULL;
                  pix_b = FULL;
               end
            end
            PAT_BARS: begin
               pix_r = bar_k[0] ? FULL : '0;
               pix_g = bar_k[1] ? FULL : '0;
               pix_b = bar_k[2] ? FULL : '0;
            end
            PAT_BORDER: begin
               if (col == '0 || col == EDGE_COL || row == '0 || row == EDGE_ROW) begin
                  pix_r = FULL;
                  pix_g = FULL;
                  pix_b = FULL;
               end
            end
            PAT_GRADIENT: begin
               pix_r = col[VIDEO_WIDTH+3:4];
               pix_g = row[VIDEO_WIDTH+3:4];
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ohsync  <= 1'b0;
         ovsync  <= 1'b0;
         olocked <= 1'b0;
         oredv   <= '0;
         ogrnv   <= '0;
         obluv   <= '0;
      end else begin
         ohsync  <= s_hsync;
         ovsync  <= s_vsync;
         olocked <= locked;
         oredv   <= pix_r;
         ogrnv   <= pix_g;
         obluv   <= pix_b;
      end
   end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomized scoreboard bench for vga_pattern_gen on a reduced raster geometry.
module tb_vga_pattern_gen;

   localparam int TC = 160;
   localparam int TR = 56;
   localparam int AC = 136;
   localparam int AR = 40;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       ihsync;
   logic       ivsync;
   logic [2:0] ipattern;
   logic       ohsync;
   logic       ovsync;
   logic [2:0] oredv;
   logic [2:0] ogrnv;
   logic [2:0] obluv;
   logic       olocked;

   vga_pattern_gen #(
      .VIDEO_WIDTH(3),
      .TOTAL_COLS (TC),
      .TOTAL_ROWS (TR),
      .ACTIVE_COLS(AC),
      .ACTIVE_ROWS(AR)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .ihsync  (ihsync),
      .ivsync  (ivsync),
      .ipattern(ipattern),
      .ohsync  (ohsync),
      .ovsync  (ovsync),
      .oredv   (oredv),
      .ogrnv   (ogrnv),
      .obluv   (obluv),
      .olocked (olocked)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       h;
      logic       v;
      logic       lk;
      logic [8:0] rgb;
      int         c;
      int         r;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model state: cycles since last frame start, lock and latched pattern.
   int   m_t      = 0;
   logic m_lock   = 1'b0;
   logic m_prev_v = 1'b1;
   int   m_pat    = 0;

   function automatic logic [8:0] ref_rgb(input int pat, input int c, input int r);
      logic [2:0] rr, gg, bb;
      int k;
      rr = 3'd0; gg = 3'd0; bb = 3'd0;
      case (pat)
         1: rr = 3'd7;
         2: gg = 3'd7;
         3: bb = 3'd7;
         4: if (((c / 32) % 2) != ((r / 32) % 2)) begin rr = 3'd7; gg = 3'd7; bb = 3'd7; end
         5: begin
            k  = c / (AC / 8);
            rr = (k % 2) ? 3'd7 : 3'd0;
            gg = ((k / 2) % 2) ? 3'd7 : 3'd0;
            bb = ((k / 4) % 2) ? 3'd7 : 3'd0;
         end
         6: if (c == 0 || c == AC - 1 || r == 0 || r == AR - 1) begin rr = 3'd7; gg = 3'd7; bb = 3'd7; end
         7: begin
            rr = 3'((c / 16) % 8);
            gg = 3'((r / 16) % 8);
         end
         default: ;
      endcase
      return {rr, gg, bb};
   endfunction

   task automatic drive_cycle(input logic rn, input logic h, input logic v, input logic [2:0] p);
      exp_t e;
      int   c, r;
      @(posedge clock);
      #1;
      reset_n  = rn;
      ihsync   = h;
      ivsync   = v;
      ipattern = p;
      if (!rn) begin
         // Entry already queued for the previous cycle is wiped by the output-stage reset.
         if (sb.size() > 0) sb[sb.size()-1] = '{h: 1'b0, v: 1'b0, lk: 1'b0, rgb: 9'd0, c: -1, r: -1};
         e = '{h: 1'b0, v: 1'b1, lk: 1'b0, rgb: 9'd0, c: -1, r: -1};
         m_prev_v = 1'b1;
         m_lock   = 1'b0;
         m_t      = 0;
      end else begin
         if (v && !m_prev_v) begin
            m_t    = 0;
            m_lock = 1'b1;
            m_pat  = int'(p);
         end else begin
            m_t++;
         end
         m_prev_v = v;
         c = m_t % TC;
         r = (m_t / TC) % TR;
         e.h  = h;
         e.v  = v;
         e.lk = m_lock;
         e.c  = c;
         e.r  = r;
         e.rgb = (m_lock && c < AC && r < AR) ? ref_rgb(m_pat, c, r) : 9'd0;
      end
      sb.push_back(e);
   endtask

   task automatic drive_frame(input logic [2:0] pat, input int rows, input int gap, input int rst_at);
      int n;
      logic [2:0] p;
      n = 0;
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < TC; c++) begin
            p = (r == 0 && c == 0) ? pat : 3'($urandom_range(0, 7));
            drive_cycle((n == rst_at) ? 1'b0 : 1'b1, c < AC, r < AR, p);
            n++;
         end
      end
      for (int i = 0; i < gap; i++) drive_cycle(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 7)));
   endtask

   // Monitor: outputs for cycle n are valid after the edge ending n+1.
   always @(negedge clock) begin
      exp_t e;
      if (sb.size() >= 3) begin
         e = sb.pop_front();
         checks++;
         if ({ohsync, ovsync} !== {e.h, e.v}) begin
            failures++;
            $display("FAIL sync col=%0d row=%0d got=%b%b exp=%b%b", e.c, e.r, ohsync, ovsync, e.h, e.v);
         end
         checks++;
         if (olocked !== e.lk) begin
            failures++;
            $display("FAIL locked col=%0d row=%0d got=%b exp=%b", e.c, e.r, olocked, e.lk);
         end
         checks++;
         if ({oredv, ogrnv, obluv} !== e.rgb) begin
            failures++;
            $display("FAIL rgb col=%0d row=%0d got=%0d,%0d,%0d exp=%0d,%0d,%0d", e.c, e.r,
                     oredv, ogrnv, obluv, e.rgb[8:6], e.rgb[5:3], e.rgb[2:0]);
         end
      end
   end

   initial begin
      reset_n  = 1'b0;
      ihsync   = 1'b0;
      ivsync   = 1'b1;
      ipattern = 3'd1;
      repeat (4) @(posedge clock);

      // ivsync high through reset release must not lock.
      for (int i = 0; i < 200; i++) drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, 3'($urandom_range(0, 7)));
      for (int i = 0; i < 50; i++)  drive_cycle(1'b1, 1'b0, 1'b0, 3'd1);

      drive_frame(3'd1, TR, 0, -1);
      drive_frame(3'd5, TR, 0, -1);
      drive_frame(3'd4, TR, 0, -1);
      drive_frame(3'd6, TR, 0, -1);
      drive_frame(3'd7, TR, 0, -1);
      // Early vsync: truncated frame, then late vsync: extra blanking past the wrap.
      drive_frame(3'd3, 12, 40, -1);
      drive_frame(3'd2, TR, 300, -1);
      // Single-cycle reset mid-line, then relock on the following frame.
      drive_frame(3'd7, TR, 0, 5 * TC + 77);
      drive_frame(3'd6, TR, 0, -1);
      for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b0, 1'b0, 3'd0);
      @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Test-pattern source placed directly upstream of the porch/sync shaping stage.
- Consumes raw active-region sync pulses from the sync pulse generator and recovers column/row counters.
- Outputs syncs plus RGB pixel data, aligned at a fixed 2-cycle latency.
- Lets the display path be brought up without a frame buffer; the pattern is selectable at runtime and only changes on frame boundaries.

Parameters:
- VIDEO_WIDTH, 3, bits per colour channel.
- TOTAL_COLS, 800, clocks per line including blanking; must be ≤ 1024.
- TOTAL_ROWS, 525, lines per frame including blanking; must be ≤ 1024.
- ACTIVE_COLS, 640, visible columns; must be a multiple of 8.
- ACTIVE_ROWS, 480, visible rows.

Ports:
- clock  in  1  pixel clock; all logic on its rising edge.
- reset_n  in  1  synchronous reset, active low.
- ihsync  in  1  high during active columns of a line, low otherwise.
- ivsync  in  1  high during active rows of a frame, low otherwise.
- ipattern  in  3  pattern select; sampled only at frame start.
- ohsync  out  1  ihsync delayed 2 cycles.
- ovsync  out  1  ivsync delayed 2 cycles.
- oredv  out  VIDEO_WIDTH  red pixel value.
- ogrnv  out  VIDEO_WIDTH  green pixel value.
- obluv  out  VIDEO_WIDTH  blue pixel value.
- olocked  out  1  high once the first frame start after reset has been seen.

Behaviour:
- Reset (reset_n low at a clock edge): ohsync, ovsync, RGB outputs, olocked, col, row and pat_q all go to 0. The stage-1 vsync sample s_vsync goes to 1, so a genuine low-to-high ivsync transition is required before lock.
- Stage 1 (edge after cycle n):
  - s_hsync <= ihsync; s_vsync <= ivsync.
  - Frame start (fs) = ivsync & ~s_vsync at cycle n.
  - If fs: col <= 0, row <= 0, pat_q <= ipattern, locked <= 1.
  - Else: col <= col+1. At TOTAL_COLS-1, col wraps to 0 and row <= row+1. Row wraps from TOTAL_ROWS-1 to 0 on a col wrap.
  - col/row are 10-bit; col/row therefore name the pixel sampled at cycle n.
- Stage 2 (edge after cycle n+1):
  - ohsync <= s_hsync; ovsync <= s_vsync; olocked <= locked.
  - RGB <= pattern(pat_q, col, row) when locked && col < ACTIVE_COLS && row < ACTIVE_ROWS; otherwise RGB <= 0.
- Latency: sync/pixel input at cycle n appears at the outputs after the edge ending cycle n+1, i.e. 2 cycles, with RGB and syncs mutually aligned.
- Patterns (F = all ones, {VIDEO_WIDTH{1}}):
  - 0: black.
  - 1: red = F.
  - 2: green = F.
  - 3: blue = F.
  - 4: checkerboard. White (all channels F) when col[5]^row[5], else black.
  - 5: colour bars. k = col / (ACTIVE_COLS/8), range 0..7; red = k[0]?F:0, green = k[1]?F:0, blue = k[2]?F:0.
  - 6: border. White when col==0, col==ACTIVE_COLS-1, row==0 or row==ACTIVE_ROWS-1; else black.
  - 7: gradient. Red = col[VIDEO_WIDTH+3:4], green = row[VIDEO_WIDTH+3:4], blue = 0.
- Pattern changes on ipattern mid-frame are ignored until the next fs. The new pattern applies starting exactly at pixel (0,0) of that frame.
- Counters free-run, wrapping, between frame starts. A frame start always resynchronises them, including early or late vsync edges, with no error state.
- Before first lock: syncs still propagate and RGB is forced to 0.
- Reset mid-frame: outputs return to 0 next edge. After release, olocked stays 0 and RGB stays 0 until the next ivsync rising edge; ivsync held high through the reset release does not lock.
- Simultaneous fs and col wrap: fs wins, so col=0, row=0.

Test Plan:
- Reset, then ivsync held 1: olocked stays 0, RGB stays 0, ohsync/ovsync track inputs with 2-cycle delay.
- Drive 800x525 timing from a reference sync generator with ipattern=1: after the first ivsync rise, olocked=1. Active pixels give oredv=7, ogrnv=0, obluv=0; blanking pixels give all 0. Pixel (0,0) output appears exactly 2 cycles after the ivsync/ihsync rise.
- ipattern=5: line 0 columns 0..79 give RGB=0,0,0; columns 80..159 give 7,0,0; columns 560..639 give 7,7,7; column 640 gives 0.
- ipattern changed from 4 to 6 mid-frame: the checkerboard continues to frame end. Next frame shows the border: row 0 all 7; row 1 gives 7 only at col 0 and col 639.
- ipattern=7 at pixel (col=37, row=100): red = 37[6:4] = 2, green = 100[6:4] = 6, blue = 0.
- reset_n pulsed low for 1 cycle mid-line: the next cycle's outputs are all 0. Relock occurs at the next ivsync rise, and counters are correct at (0,0).
